tns_decoder_25: RTL and testbench
=================================

// Module: tns_decoder_25
// PURPOSE
//  Receive-side decoder for the 25-wire TNS crosstalk-avoidance bus. Recovers
//  the BLEN09_C-bit data word from a 25-bit TNS codeword as the weighted sum
//  of its set bits. Sits at the bus far end, opposite the 25-bit TNS encoder.
//  Two-stage valid/ready pipeline; also flags out-of-range words and
//  opposite-direction switching on adjacent wires between consecutive words.
// PARAMETERS
//  DW  `BLEN09_C  data width; fixed by TNS.vh, not overridden per instance
//  CW  25         codeword width; fixed, only 25 is supported
// PORTS
//  clock      in   1   single clock, rising edge
//  reset_n    in   1   asynchronous active-low reset
//  codein     in   25  TNS codeword; bit 24 is the MSB weight
//  in_valid   in   1   codein is valid this cycle
//  in_ready   out  1   decoder accepts codein this cycle
//  dataout    out  DW  decoded data word
//  out_valid  out  1   dataout, err_range and err_xtalk are valid
//  out_ready  in   1   downstream consumes dataout this cycle
//  err_range  out  1   decoded sum >= 2**DW; dataout holds the sum mod 2**DW
//  err_xtalk  out  1   opposite transition on an adjacent wire pair vs the previous word
// BEHAVIOUR
//  Weights, bit 24 down to bit 0:
//   TNS09_C, then {TNS0k_A, TNS0k_B, TNS0k_C} for k = 8 down to 2
//   (bits 23..3), then TNS01_A, TNS01_B, 1.
//   The A-bit and B+C-bit forms of one value decode to the same data.
//  Handshake:
//   - Accept when in_valid & in_ready.
//   - Output transfer when out_valid & out_ready.
//   - adv2 = ~v2 | out_ready.
//   - in_ready = ~v1 | adv2 (combinational; no in_valid -> in_ready path).
//   - Full throughput: one word per cycle while out_ready stays 1.
//   - While stalled, dataout, err_range and err_xtalk hold stable.
//  Stage 1 (on accept):
//   - Register 9 group partial sums: group 9 is bit 24; groups 8..1 are
//     3-bit triplets, with group 1 including the unit bit 0.
//   - Register the xtalk flag.
//   - Set v1.
//  Stage 2 (on adv2):
//   - Sum the partials at DW+1 bits into dataout (low DW bits).
//   - Set err_range from bit DW.
//   - v2 <= v1.
//   - If adv2 is 1 while v1 is 0, v2 clears.
//  Latency: 2 cycles from accept to out_valid when not stalled.
//  Xtalk check:
//   - prev holds the last accepted codeword; prev_vld is set on the first accept.
//   - Flag when, for any i in 0..23: codein[i] != prev[i], codein[i+1] != prev[i+1],
//     and codein[i] != codein[i+1].
//   - The first word after reset is never flagged.
//   - prev updates only on accept; stalls and bubbles do not update it.
//  Reset:
//   - Async assert clears v1, v2, prev, prev_vld and all partials.
//   - Output reset values: out_valid=0, dataout=0, err_range=0, err_xtalk=0.
//   - in_ready=1 during reset.
//   - Reset mid-operation drops in-flight words with no output; deassertion
//     is synchronised by the parent.
//  Simultaneous events: accept and output transfer in the same cycle both
//   happen; the pipeline advances without a bubble.
// STRUCTURE
//  - TNS.vh (shared) supplies BLEN09_C and the TNS0k_{A,B,C} weights; add
//    TNS_CW=25 there.
//  - One sub-module, tns_group_sum: a 3-bit triplet times 3 weight parameters
//    gives the partial. Instantiated 8 times; group 9 is inline.
//  - The xtalk check and the pipeline control live in the top module.
// TESTING
//  - Reset, then codein=0 with in_valid=1: out_valid rises 2 cycles later;
//    dataout=0, err_range=0, err_xtalk=0.
//  - codein=25'h0000001, then 25'h0000004: dataout=1, then dataout=TNS01_A.
//  - Equivalent forms: bit 5 alone, then bits 4 and 3: both give dataout=TNS02_A.
//  - Stall: drive 4 words back-to-back with out_ready=0 for 3 cycles.
//    in_ready drops after 2 words; no loss or duplication; in-order outputs
//    once out_ready=1.
//  - Xtalk: 25'b01 then 25'b10 -> second output has err_xtalk=1;
//    25'b00 then 25'b11 -> err_xtalk=0.
//  - Range: codein=all ones -> err_range=1. Assert reset_n low with 2 words
//    in flight -> out_valid=0 immediately, and no output after release.
//  - Scoreboard: 10k random encoder-produced codewords plus random
//    out_ready; decoded data matches the encoder input.

Source files
------------

// File: rtl/tns_decoder_25_pkg.sv
// Shared constants for the 25-wire TNS bus receive path.
//   BLEN09_C     data word width recovered from a 25-bit codeword
//   TNS_CW       codeword width (25 wires)
//   TNS0k_{A,B,C} wire weights for triplet k, where A = B + C, so a single
//                A bit and the B+C pair carry the same value
//   TNS09_C      weight of the top wire (bit 24)
//   tns_weight() weight of a codeword bit by position, 0..24
//   tns_s1_t     first pipeline stage payload (group partials + xtalk flag)
package tns_decoder_25_pkg;

    localparam int BLEN09_C = 17;
    localparam int TNS_CW   = 25;
    localparam int TNS_NGRP = 9;              // 8 triplets + the lone top bit
    localparam int TNS_SW   = BLEN09_C + 1;   // one guard bit for range detection

    // Each weight is the sum of the two below it, starting from 1, 1.
    localparam int unsigned TNS01_B = 1;
    localparam int unsigned TNS01_A = 2;
    localparam int unsigned TNS02_C = 3;
    localparam int unsigned TNS02_B = 5;
    localparam int unsigned TNS02_A = 8;
    localparam int unsigned TNS03_C = 13;
    localparam int unsigned TNS03_B = 21;
    localparam int unsigned TNS03_A = 34;
    localparam int unsigned TNS04_C = 55;
    localparam int unsigned TNS04_B = 89;
    localparam int unsigned TNS04_A = 144;
    localparam int unsigned TNS05_C = 233;
    localparam int unsigned TNS05_B = 377;
    localparam int unsigned TNS05_A = 610;
    localparam int unsigned TNS06_C = 987;
    localparam int unsigned TNS06_B = 1597;
    localparam int unsigned TNS06_A = 2584;
    localparam int unsigned TNS07_C = 4181;
    localparam int unsigned TNS07_B = 6765;
    localparam int unsigned TNS07_A = 10946;
    localparam int unsigned TNS08_C = 17711;
    localparam int unsigned TNS08_B = 28657;
    localparam int unsigned TNS08_A = 46368;
    localparam int unsigned TNS09_C = 75025;

    typedef struct packed {
        logic [TNS_NGRP-1:0][TNS_SW-1:0] part;
        logic                            xtalk;
    } tns_s1_t;

    // Weight of codeword bit 'bitpos'; 0 for out-of-range positions.
    function automatic int unsigned tns_weight(input int bitpos);
        case (bitpos)
            0:       return 1;
            1:       return TNS01_B;
            2:       return TNS01_A;
            3:       return TNS02_C;
            4:       return TNS02_B;
            5:       return TNS02_A;
            6:       return TNS03_C;
            7:       return TNS03_B;
            8:       return TNS03_A;
            9:       return TNS04_C;
            10:      return TNS04_B;
            11:      return TNS04_A;
            12:      return TNS05_C;
            13:      return TNS05_B;
            14:      return TNS05_A;
            15:      return TNS06_C;
            16:      return TNS06_B;
            17:      return TNS06_A;
            18:      return TNS07_C;
            19:      return TNS07_B;
            20:      return TNS07_A;
            21:      return TNS08_C;
            22:      return TNS08_B;
            23:      return TNS08_A;
            24:      return TNS09_C;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/tns_decoder_25_group_sum.sv
// Partial sum of one codeword triplet.
//   trip  in  3  triplet bits, trip[2] carries weight WA, trip[0] weight WC
//   sum   out W  WA*trip[2] + WB*trip[1] + WC*trip[0]
module tns_group_sum #(
    parameter int          W  = 18,
    parameter int unsigned WA = 0,
    parameter int unsigned WB = 0,
    parameter int unsigned WC = 0
) (
    input  logic [2:0]   trip,
    output logic [W-1:0] sum
);

    assign sum = (trip[2] ? W'(WA) : '0)
               + (trip[1] ? W'(WB) : '0)
               + (trip[0] ? W'(WC) : '0);

endmodule

// File: rtl/tns_decoder_25.sv
// TNS 25-wire bus decoder: recovers the data word as the weighted sum of the
// set codeword bits, flags sums that overflow the data width and flags
// opposite-direction switching on adjacent wires between accepted words.
// Two-stage valid/ready pipeline, one word per cycle when not stalled.
//   clock      in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   codein     in   CW  codeword, bit 24 carries the largest weight
//   in_valid   in   1   codein valid
//   in_ready   out  1   codein accepted this cycle when in_valid is high
//   dataout    out  DW  decoded word (sum modulo 2**DW)
//   out_valid  out  1   dataout / err_range / err_xtalk valid
//   out_ready  in   1   downstream takes the output this cycle
//   err_range  out  1   decoded sum did not fit in DW bits
//   err_xtalk  out  1   adjacent wires switched in opposite directions
module tns_decoder_25
    import tns_decoder_25_pkg::*;
#(
    parameter int DW = BLEN09_C,
    parameter int CW = TNS_CW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [CW-1:0] codein,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] dataout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err_range,
    output logic          err_xtalk
);

    logic          v1;
    logic          v2;
    logic          adv2;
    logic          accept;
    logic [CW-1:0] prev;
    logic          prev_vld;

    logic [TNS_SW-1:0] part_d [TNS_NGRP];
    tns_s1_t           s1_d;
    tns_s1_t           s1_q;
    logic [TNS_SW-1:0] sum;

    logic [CW-1:0] diff;
    logic [CW-2:0] opp;

    // Handshake. in_ready depends only on pipeline state and out_ready.
    assign adv2     = ~v2 | out_ready;
    assign in_ready = ~v1 | adv2;
    assign accept   = in_valid & in_ready;
    assign out_valid = v2;

    // Triplet groups 1..8 cover bits 23..0; group 1 holds the unit bit.
    for (genvar g = 1; g <= 8; g++) begin : g_grp
        tns_group_sum #(
            .W  (TNS_SW),
            .WA (tns_weight(3*g-1)),
            .WB (tns_weight(3*g-2)),
            .WC (tns_weight(3*g-3))
        ) u_sum (
            .trip (codein[3*g-1 -: 3]),
            .sum  (part_d[g-1])
        );
    end

    // Group 9 is the single top wire.
    assign part_d[8] = codein[CW-1] ? TNS_SW'(TNS09_C) : '0;

    // A pair of neighbours both toggling to different levels means one rose
    // while the other fell.
    assign diff = codein ^ prev;
    assign opp  = diff[CW-2:0] & diff[CW-1:1] & (codein[CW-2:0] ^ codein[CW-1:1]);

    always_comb begin
        s1_d       = '0;
        s1_d.xtalk = prev_vld & (|opp);
        for (int g = 0; g < TNS_NGRP; g++) begin
            s1_d.part[g] = part_d[g];
        end
    end

    // Guard bit keeps the overflow visible; the full 25-wire sum fits in TNS_SW.
    always_comb begin
        sum = '0;
        for (int g = 0; g < TNS_NGRP; g++) begin
            sum = sum + s1_q.part[g];
        end
    end

    // Stage 1: capture partials and xtalk; prev tracks accepted words only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            v1       <= 1'b0;
            prev     <= '0;
            prev_vld <= 1'b0;
        end else begin
            if (accept) begin
                s1_q     <= s1_d;
                v1       <= 1'b1;
                prev     <= codein;
                prev_vld <= 1'b1;
            end else if (adv2) begin
                v1 <= 1'b0;
            end
        end
    end

    // Stage 2: outputs only change when the stage advances, so a stalled
    // word holds. A bubble clears v2 but leaves the last data in place.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v2        <= 1'b0;
            dataout   <= '0;
            err_range <= 1'b0;
            err_xtalk <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                dataout   <= sum[DW-1:0];
                err_range <= sum[DW];
                err_xtalk <= s1_q.xtalk;
            end
        end
    end

endmodule

// File: tb/tb_tns_decoder_25.sv
module tb_tns_decoder_25;

    localparam int DW = 17;
    localparam int NV = 15;
    localparam int NSB = 10000;

    logic          clock;
    logic          reset_n;
    logic [24:0]   codein;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dataout;
    logic          out_valid;
    logic          out_ready;
    logic          err_range;
    logic          err_xtalk;

    int total = 0;
    int bad   = 0;
    int w [25];

    tns_decoder_25 dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .codein    (codein),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataout   (dataout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_range (err_range),
        .err_xtalk (err_xtalk)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [24:0] code;
        int          data;
        int          rng;
        int          xt;
    } vec_t;

    typedef struct {
        int data;
        int xt;
    } exp_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int xt_model(input logic [24:0] p, input bit pv, input logic [24:0] c);
        if (!pv) return 0;
        for (int i = 0; i < 24; i++)
            if (c[i] != p[i] && c[i+1] != p[i+1] && c[i] != c[i+1]) return 1;
        return 0;
    endfunction

    // Greedy encoder, optionally rewriting some A bits as the equivalent B+C pair.
    function automatic logic [24:0] enc(input int d);
        logic [24:0] c;
        int r;
        c = '0;
        r = d;
        for (int i = 24; i >= 0; i--)
            if (r >= w[i]) begin
                c[i] = 1'b1;
                r -= w[i];
            end
        for (int i = 24; i >= 2; i--)
            if (c[i] && !c[i-1] && !c[i-2] && $urandom_range(0, 1) == 1) begin
                c[i]   = 1'b0;
                c[i-1] = 1'b1;
                c[i-2] = 1'b1;
            end
        return c;
    endfunction

    vec_t vecs [NV];
    logic [24:0] sw [4];
    int          se [4];
    exp_t        q [$];

    initial begin
        int lat, idx, got, ovc, sent, rcvd, cur_d;
        bit acc, mpv;
        logic [24:0] mprev, cur_c;
        exp_t e;

        w[0] = 1;
        w[1] = 1;
        for (int i = 2; i < 25; i++) w[i] = w[i-1] + w[i-2];

        vecs[0]  = '{25'h0000000,      0, 0, 0};
        vecs[1]  = '{25'h0000001,      1, 0, 0};
        vecs[2]  = '{25'h0000004,      2, 0, 0};
        vecs[3]  = '{25'h0000020,      8, 0, 0};
        vecs[4]  = '{25'h0000018,      8, 0, 1};
        vecs[5]  = '{25'h0000001,      1, 0, 0};
        vecs[6]  = '{25'h0000002,      1, 0, 1};
        vecs[7]  = '{25'h0000000,      0, 0, 0};
        vecs[8]  = '{25'h0000003,      2, 0, 0};
        vecs[9]  = '{25'h1FFFFFF,  65345, 1, 0};
        vecs[10] = '{25'h1000000,  75025, 0, 0};
        vecs[11] = '{25'h1800000, 121393, 0, 0};
        vecs[12] = '{25'h0A00000,  64079, 0, 0};
        vecs[13] = '{25'h1400000, 103682, 0, 1};
        vecs[14] = '{25'h1C00000,  18978, 1, 0};

        sw = '{25'h0000001, 25'h0000004, 25'h0000008, 25'h0000010};
        se = '{1, 2, 3, 5};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        codein    = '0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_dataout", int'(dataout), 0);
        chk("rst_err_range", int'(err_range), 0);
        chk("rst_err_xtalk", int'(err_xtalk), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed table: one word at a time, latency and outputs.
        for (int v = 0; v < NV; v++) begin
            @(posedge clock); #1;
            codein   = vecs[v].code;
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(posedge clock); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 6) begin
                @(posedge clock); #1;
                lat++;
            end
            chk($sformatf("vec%0d_latency", v), lat, 2);
            chk($sformatf("vec%0d_data", v), int'(dataout), vecs[v].data);
            chk($sformatf("vec%0d_range", v), int'(err_range), vecs[v].rng);
            chk($sformatf("vec%0d_xtalk", v), int'(err_xtalk), vecs[v].xt);
        end

        // Stall: 4 back-to-back words, out_ready low for 3 cycles.
        idx = 0;
        got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(posedge clock); #1;
            out_ready = (c >= 3);
            in_valid  = (idx < 4);
            codein    = (idx < 4) ? sw[idx] : '0;
            #3;
            if (c == 2) begin
                chk("stall_in_ready", int'(in_ready), 0);
                chk("stall_accepted", idx, 2);
                chk("stall_hold_valid", int'(out_valid), 1);
                chk("stall_hold_data", int'(dataout), 1);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("stall_out%0d", got), int'(dataout), se[got]);
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("stall_out_count", got, 4);
        chk("stall_in_count", idx, 4);
        ovc = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            if (out_valid) ovc++;
        end
        chk("stall_no_dup", ovc, 0);

        // Reset with two words in flight.
        @(posedge clock); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        codein    = 25'h0000001;
        @(posedge clock); #1;
        codein    = 25'h0000004;
        @(posedge clock); #1;
        in_valid  = 1'b0;
        chk("flight_out_valid", int'(out_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_out_valid", int'(out_valid), 0);
        chk("rstmid_dataout", int'(dataout), 0);
        chk("rstmid_in_ready", int'(in_ready), 1);
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        ovc = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            if (out_valid) ovc++;
        end
        chk("rstmid_no_output", ovc, 0);

        // Scoreboard: random encoder words, random backpressure.
        mpv   = 1'b0;
        mprev = '0;
        sent  = 0;
        rcvd  = 0;
        cur_d = $urandom_range(0, 121392);
        cur_c = enc(cur_d);
        for (int c = 0; c < 60000 && rcvd < NSB; c++) begin
            @(posedge clock); #1;
            in_valid  = (sent < NSB) && ($urandom_range(0, 9) < 8);
            codein    = cur_c;
            out_ready = ($urandom_range(0, 9) < 7);
            #3;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", int'(dataout), e.data);
                    chk("sb_xtalk", int'(err_xtalk), e.xt);
                    chk("sb_range", int'(err_range), 0);
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                e.data = cur_d;
                e.xt   = xt_model(mprev, mpv, cur_c);
                q.push_back(e);
                mprev = cur_c;
                mpv   = 1'b1;
                sent++;
                cur_d = $urandom_range(0, 121392);
                cur_c = enc(cur_d);
            end
        end
        in_valid = 1'b0;
        chk("sb_count", rcvd, NSB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
